mem_ctrl: RTL and testbench

- Responder end of the load/store memory protocol: serves byte-serial single-port RAM on behalf of two requesters.
- Requesters are the load-store buffer (data, 1/2/4-byte loads and stores) and the instruction fetcher (4-byte reads).
- Sequences byte accesses, assembles and sign/zero-extends load data, and returns a one-cycle valid pulse to the winning requester.
- Sits between the execute/fetch stages and the external RAM port.

---
 rtl/mem_ctrl_if.sv | 59 +++++
 rtl/mem_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/response and RAM-side signals of the memory controller.
//
// Ports (grouped as interface signals):
//   rdy, wrong_commit            global enable and pipeline flush
//   lsb_*                        load-store buffer request / completion
//   if_*                         instruction fetch request / completion
//   mem_din, mem_dout, mem_a,
//   mem_wr                       byte-serial single-port RAM
//
// Handshake: a requester raises *_enable with its address (and data/op) and
// holds all of them stable until it samples its *_mem_valid high. *_mem_valid
// is a one-cycle pulse; *_mem_res is valid in that cycle and holds its value
// until the next completion to the same requester.
//
// Modports: slave = the controller, master = the requesters plus the RAM.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              rdy;
    logic              wrong_commit;

    logic              lsb_enable;
    logic [ADDR_W-1:0] lsb_addr;
    logic [31:0]       lsb_data;
    logic              lsb_load;
    logic [4:0]        lsb_op;
    logic              lsb_mem_valid;
    logic [31:0]       lsb_mem_res;

    logic              if_enable;
    logic [ADDR_W-1:0] if_addr;
    logic              if_mem_valid;
    logic [31:0]       if_mem_res;

    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    modport slave (
        input  rdy, wrong_commit,
        input  lsb_enable, lsb_addr, lsb_data, lsb_load, lsb_op,
        output lsb_mem_valid, lsb_mem_res,
        input  if_enable, if_addr,
        output if_mem_valid, if_mem_res,
        input  mem_din,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output rdy, wrong_commit,
        output lsb_enable, lsb_addr, lsb_data, lsb_load, lsb_op,
        input  lsb_mem_valid, lsb_mem_res,
        output if_enable, if_addr,
        input  if_mem_valid, if_mem_res,
        output mem_din,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: responder for the load-store buffer and the instruction fetcher,
// serving them from a byte-serial single-port RAM. Loads are assembled
// little-endian and sign/zero-extended; stores are written one byte per cycle.
// The LSB has priority over fetch. A one-edge DONE cooldown follows every
// completion so a requester that is still holding enable is not re-served.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        mem_ctrl_if.slave (requests, completions, RAM port)
//   dbg_state  current FSM state (0 IDLE, 1 LSB_RD, 2 LSB_WR, 3 IF_RD, 4 DONE)
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_ctrl_if.slave     bus,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LSB_RD = 3'd1,
        LSB_WR = 3'd2,
        IF_RD  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state;
    logic [1:0]        cnt;     // index of the byte currently on the RAM port
    logic [ADDR_W-1:0] base;    // start address of the access
    logic [31:0]       wdata;   // store data
    logic [2:0]        op;      // funct3; fetches are recorded as W
    logic [31:0]       rbuf;    // bytes captured so far (upper bytes stay 0)

    logic [1:0]        last;
    logic [31:0]       word;
    logic [ADDR_W-1:0] next_a;
    logic [4:0]        wsh;
    logic [7:0]        wnext;
    logic              unused_op_hi;

    // Index of the final byte: N-1 for N = 1, 2 or 4. Unlisted codes are words.
    function automatic logic [1:0] last_idx(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: last_idx = 2'd0;
            3'b001, 3'b101: last_idx = 2'd1;
            default:        last_idx = 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'b000:  extend = {{24{w[7]}}, w[7:0]};
            3'b001:  extend = {{16{w[15]}}, w[15:0]};
            3'b100:  extend = {24'd0, w[7:0]};
            3'b101:  extend = {16'd0, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    assign last         = last_idx(op);
    assign next_a       = base + ADDR_W'(cnt) + ADDR_W'(1);  // wraps modulo 2^ADDR_W
    assign wsh          = {cnt + 2'd1, 3'b000};
    assign wnext        = wdata[wsh +: 8];
    assign unused_op_hi = ^bus.lsb_op[4:3];
    assign dbg_state    = state;

    // Captured bytes merged with the byte arriving on mem_din this cycle.
    always_comb begin
        word = rbuf;
        case (cnt)
            2'd0:    word[7:0]   = bus.mem_din;
            2'd1:    word[15:8]  = bus.mem_din;
            2'd2:    word[23:16] = bus.mem_din;
            default: word[31:24] = bus.mem_din;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= 2'd0;
            base              <= '0;
            wdata             <= 32'd0;
            op                <= 3'd0;
            rbuf              <= 32'd0;
            bus.lsb_mem_valid <= 1'b0;
            bus.lsb_mem_res   <= 32'd0;
            bus.if_mem_valid  <= 1'b0;
            bus.if_mem_res    <= 32'd0;
            bus.mem_dout      <= 8'd0;
            bus.mem_a         <= '0;
            bus.mem_wr        <= 1'b0;
        end else if (bus.rdy) begin
            bus.lsb_mem_valid <= 1'b0;
            bus.if_mem_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    // A flush in the same cycle as a request cancels it.
                    if (!bus.wrong_commit) begin
                        if (bus.lsb_enable) begin
                            base      <= bus.lsb_addr;
                            wdata     <= bus.lsb_data;
                            op        <= bus.lsb_op[2:0];
                            cnt       <= 2'd0;
                            rbuf      <= 32'd0;
                            bus.mem_a <= bus.lsb_addr;
                            if (bus.lsb_load) begin
                                bus.mem_wr <= 1'b0;
                                state      <= LSB_RD;
                            end else begin
                                bus.mem_wr   <= 1'b1;
                                bus.mem_dout <= bus.lsb_data[7:0];
                                state        <= LSB_WR;
                            end
                        end else if (bus.if_enable) begin
                            base       <= bus.if_addr;
                            op         <= 3'b010;
                            cnt        <= 2'd0;
                            rbuf       <= 32'd0;
                            bus.mem_a  <= bus.if_addr;
                            bus.mem_wr <= 1'b0;
                            state      <= IF_RD;
                        end
                    end
                end

                LSB_RD, IF_RD: begin
                    if (bus.wrong_commit) begin
                        // Speculative read: drop it, including on its final byte.
                        bus.mem_a <= '0;
                        cnt       <= 2'd0;
                        state     <= IDLE;
                    end else if (cnt == last) begin
                        bus.mem_a <= '0;
                        cnt       <= 2'd0;
                        state     <= DONE;
                        if (state == LSB_RD) begin
                            bus.lsb_mem_valid <= 1'b1;
                            bus.lsb_mem_res   <= extend(op, word);
                        end else begin
                            bus.if_mem_valid <= 1'b1;
                            bus.if_mem_res   <= word;
                        end
                    end else begin
                        rbuf      <= word;
                        bus.mem_a <= next_a;
                        cnt       <= cnt + 2'd1;
                    end
                end

                LSB_WR: begin
                    // Stores are already committed; a flush does not stop them.
                    if (cnt == last) begin
                        bus.mem_wr        <= 1'b0;
                        bus.mem_dout      <= 8'd0;
                        bus.mem_a         <= '0;
                        bus.lsb_mem_valid <= 1'b1;
                        bus.lsb_mem_res   <= 32'd0;
                        cnt               <= 2'd0;
                        state             <= DONE;
                    end else begin
                        bus.mem_a    <= next_a;
                        bus.mem_dout <= wnext;
                        cnt          <= cnt + 2'd1;
                    end
                end

                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl with a byte RAM model
// (combinational read of the registered address, write on the clock edge).
module tb_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dbg_state;

    mem_ctrl_if #(.ADDR_W(32)) bus();

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    logic [7:0]  ram   [0:4095];
    logic [7:0]  model [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_a  = 12'd0;
    logic [7:0]  pre_d  = 8'd0;

    assign bus.mem_din = ram[bus.mem_a[11:0]];

    always @(posedge clk) begin
        if (pre_we)
            ram[pre_a] <= pre_d;
        else if (bus.mem_wr)
            ram[bus.mem_a[11:0]] <= bus.mem_dout;
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] if_exp_q[$];
    int errors = 0;
    int checks = 0;

    int          edges;
    logic        got;
    logic [31:0] tr_a  [0:31];
    logic        tr_wr [0:31];
    logic [7:0]  tr_d  [0:31];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        load;
        logic [4:0]  op;
        logic [31:0] res;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [0:NV-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        pre_we = 1'b1;
        pre_a  = a[11:0];
        pre_d  = d;
        model[a[11:0]] = d;
        step();
        pre_we = 1'b0;
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: size_of = 1;
            3'b001, 3'b101: size_of = 2;
            default:        size_of = 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] w;
        logic [31:0] s;
        w = 32'd0;
        for (int i = 0; i < size_of(f3); i++) begin
            s = a + 32'(i);
            w[8*i +: 8] = model[s[11:0]];
        end
        case (f3)
            3'b000:  model_load = {{24{w[7]}}, w[7:0]};
            3'b001:  model_load = {{16{w[15]}}, w[15:0]};
            default: model_load = w;
        endcase
    endfunction

    // Issue one LSB request, trace the RAM port each edge, then compare the
    // completion against the scoreboard and confirm the pulse is one cycle.
    task automatic lsb_req(input logic [31:0] a, input logic [31:0] d, input logic ld,
                           input logic [4:0] op, input logic [31:0] exp);
        logic [31:0] want;
        exp_q.push_back(exp);
        bus.lsb_enable = 1'b1;
        bus.lsb_addr   = a;
        bus.lsb_data   = d;
        bus.lsb_load   = ld;
        bus.lsb_op     = op;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 20) begin
            step();
            tr_a[edges]  = bus.mem_a;
            tr_wr[edges] = bus.mem_wr;
            tr_d[edges]  = bus.mem_dout;
            edges++;
            if (bus.lsb_mem_valid) got = 1'b1;
        end
        bus.lsb_enable = 1'b0;
        check("lsb_valid_seen", got, 1);
        want = exp_q.pop_front();
        if (got) check("lsb_res", bus.lsb_mem_res, want);
        step();
        check("lsb_pulse_one_cycle", bus.lsb_mem_valid, 0);
    endtask

    initial begin
        int          n;
        int          lsb_edge;
        int          if_edge;
        int          vcount;
        logic [31:0] sum;
        logic [31:0] ra;
        logic [2:0]  rop;
        logic [2:0]  rops [0:4];

        rops[0] = 3'b000; rops[1] = 3'b001; rops[2] = 3'b010;
        rops[3] = 3'b100; rops[4] = 3'b101;

        vecs[0]  = '{32'h100,      32'h0,        1'b1, 5'b00010, 32'hF2345678};
        vecs[1]  = '{32'h103,      32'h0,        1'b1, 5'b00000, 32'hFFFFFFF2};
        vecs[2]  = '{32'h103,      32'h0,        1'b1, 5'b00100, 32'h000000F2};
        vecs[3]  = '{32'h102,      32'h0,        1'b1, 5'b00001, 32'hFFFFF234};
        vecs[4]  = '{32'h102,      32'h0,        1'b1, 5'b00101, 32'h0000F234};
        vecs[5]  = '{32'h200,      32'hAABBCCDD, 1'b0, 5'b00001, 32'h0};
        vecs[6]  = '{32'h200,      32'h0,        1'b1, 5'b11010, 32'h2211CCDD};
        vecs[7]  = '{32'h204,      32'h1234565A, 1'b0, 5'b00000, 32'h0};
        vecs[8]  = '{32'h204,      32'h0,        1'b1, 5'b00000, 32'h0000005A};
        vecs[9]  = '{32'h100,      32'h0,        1'b1, 5'b00011, 32'hF2345678};
        vecs[10] = '{32'h100,      32'h0,        1'b1, 5'b00001, 32'h00005678};
        vecs[11] = '{32'h208,      32'h80FF0102, 1'b0, 5'b00010, 32'h0};
        vecs[12] = '{32'h208,      32'h0,        1'b1, 5'b00010, 32'h80FF0102};
        vecs[13] = '{32'h20A,      32'h0,        1'b1, 5'b00001, 32'hFFFF80FF};
        vecs[14] = '{32'h209,      32'h0,        1'b1, 5'b00100, 32'h00000001};
        vecs[15] = '{32'hFFFFFFFE, 32'h0,        1'b1, 5'b00010, 32'h66554433};
        vecs[16] = '{32'hFFFFFFFF, 32'h0,        1'b1, 5'b00101, 32'h00005544};

        // ---------------- clock / reset ----------------
        rst              = 1'b1;
        bus.rdy          = 1'b1;
        bus.wrong_commit = 1'b0;
        bus.lsb_enable   = 1'b0;
        bus.lsb_addr     = 32'd0;
        bus.lsb_data     = 32'd0;
        bus.lsb_load     = 1'b0;
        bus.lsb_op       = 5'd0;
        bus.if_enable    = 1'b0;
        bus.if_addr      = 32'd0;
        for (int i = 0; i < 4096; i++) model[i] = 8'd0;
        step();
        step();
        check("rst_lsb_valid", bus.lsb_mem_valid, 0);
        check("rst_lsb_res",   bus.lsb_mem_res,   0);
        check("rst_if_valid",  bus.if_mem_valid,  0);
        check("rst_if_res",    bus.if_mem_res,    0);
        check("rst_mem_dout",  bus.mem_dout,      0);
        check("rst_mem_a",     bus.mem_a,         0);
        check("rst_mem_wr",    bus.mem_wr,        0);
        check("rst_state",     dbg_state,         0);
        rst = 1'b0;
        step();

        // ---------------- RAM contents ----------------
        preload(32'h100, 8'h78); preload(32'h101, 8'h56);
        preload(32'h102, 8'h34); preload(32'h103, 8'hF2);
        preload(32'h202, 8'h11); preload(32'h203, 8'h22);
        preload(32'h205, 8'h99); preload(32'h20C, 8'hEE);
        preload(32'hFFE, 8'h33); preload(32'hFFF, 8'h44);
        preload(32'h000, 8'h55); preload(32'h001, 8'h66);
        preload(32'h600, 8'hEF); preload(32'h601, 8'hBE);
        preload(32'h602, 8'hAD); preload(32'h603, 8'hDE);
        for (int i = 0; i < 5; i++) preload(32'h700 + 32'(i), 8'h00);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NV; i++) begin
            n = size_of(vecs[i].op[2:0]);
            lsb_req(vecs[i].addr, vecs[i].data, vecs[i].load, vecs[i].op, vecs[i].res);
            check($sformatf("v%0d_edges_to_valid", i), edges, n + 1);
            if (edges > n) begin
                for (int k = 0; k < n; k++) begin
                    sum = vecs[i].addr + 32'(k);
                    check($sformatf("v%0d_addr%0d", i, k), tr_a[k], sum);
                    check($sformatf("v%0d_wr%0d", i, k), tr_wr[k], !vecs[i].load);
                    if (!vecs[i].load)
                        check($sformatf("v%0d_byte%0d", i, k), tr_d[k], 8'(vecs[i].data >> (8*k)));
                end
                check($sformatf("v%0d_addr_end", i), tr_a[n], 0);
                check($sformatf("v%0d_wr_end", i), tr_wr[n], 0);
            end
            if (!vecs[i].load) begin
                for (int k = 0; k < n; k++) begin
                    sum = vecs[i].addr + 32'(k);
                    model[sum[11:0]] = 8'(vecs[i].data >> (8*k));
                end
                for (int k = 0; k <= n; k++) begin
                    sum = vecs[i].addr + 32'(k);
                    check($sformatf("v%0d_ram%0d", i, k), ram[sum[11:0]], model[sum[11:0]]);
                end
            end
        end

        // ---------------- random loads against the model ----------------
        for (int r = 0; r < 6; r++) begin
            ra = 32'h400 + 32'($urandom_range(0, 200));
            for (int k = 0; k < 4; k++) preload(ra + 32'(k), 8'($urandom_range(0, 255)));
            rop = rops[$urandom_range(0, 4)];
            lsb_req(ra, 32'd0, 1'b1, {2'b00, rop}, model_load(ra, rop));
            check("rand_edges", edges, size_of(rop) + 1);
        end

        // ---------------- LSB and fetch on the same edge ----------------
        exp_q.push_back(32'hF2345678);
        if_exp_q.push_back(32'hDEADBEEF);
        bus.lsb_enable = 1'b1; bus.lsb_addr = 32'h100; bus.lsb_load = 1'b1; bus.lsb_op = 5'b00010;
        bus.if_enable  = 1'b1; bus.if_addr  = 32'h600;
        lsb_edge = 0;
        if_edge  = 0;
        for (int e = 1; e <= 30 && if_edge == 0; e++) begin
            step();
            if (e == 6) check("arb_gap_addr", bus.mem_a, 0);
            if (e == 7) check("arb_fetch_start", bus.mem_a, 32'h600);
            if (bus.lsb_mem_valid) begin
                lsb_edge = e;
                bus.lsb_enable = 1'b0;
                check("arb_lsb_res", bus.lsb_mem_res, exp_q.pop_front());
            end
            if (bus.if_mem_valid) begin
                if_edge = e;
                bus.if_enable = 1'b0;
                check("arb_if_res", bus.if_mem_res, if_exp_q.pop_front());
            end
        end
        bus.lsb_enable = 1'b0;
        bus.if_enable  = 1'b0;
        check("arb_lsb_edge", lsb_edge, 5);
        check("arb_if_edge", if_edge, 11);
        step();

        // ---------------- flush on the second byte of a fetch ----------------
        bus.if_enable = 1'b1; bus.if_addr = 32'h600;
        step();
        check("wc_if_addr0", bus.mem_a, 32'h600);
        step();
        check("wc_if_addr1", bus.mem_a, 32'h601);
        bus.wrong_commit = 1'b1;
        step();
        bus.wrong_commit = 1'b0;
        bus.if_enable    = 1'b0;
        check("wc_if_state", dbg_state, 0);
        check("wc_if_addr_zero", bus.mem_a, 0);
        vcount = 0;
        if (bus.if_mem_valid) vcount++;
        for (int j = 0; j < 6; j++) begin
            step();
            if (bus.if_mem_valid) vcount++;
        end
        check("wc_if_no_valid", vcount, 0);

        // ---------------- flush on the completion edge of a byte load ----------------
        bus.lsb_enable = 1'b1; bus.lsb_addr = 32'h103; bus.lsb_load = 1'b1; bus.lsb_op = 5'b00000;
        step();
        check("wc_lb_state", dbg_state, 1);
        bus.wrong_commit = 1'b1;
        step();
        bus.wrong_commit = 1'b0;
        bus.lsb_enable   = 1'b0;
        check("wc_lb_no_valid", bus.lsb_mem_valid, 0);
        check("wc_lb_state_idle", dbg_state, 0);
        step();

        // ---------------- flush during a word store ----------------
        exp_q.push_back(32'h0);
        bus.lsb_enable = 1'b1; bus.lsb_addr = 32'h700; bus.lsb_data = 32'hC0FFEE11;
        bus.lsb_load = 1'b0; bus.lsb_op = 5'b00010;
        step();
        bus.wrong_commit = 1'b1;
        edges = 1;
        got   = 1'b0;
        while (!got && edges < 20) begin
            step();
            edges++;
            if (bus.lsb_mem_valid) got = 1'b1;
        end
        bus.wrong_commit = 1'b0;
        bus.lsb_enable   = 1'b0;
        check("wc_sw_edges", edges, 5);
        check("wc_sw_res", bus.lsb_mem_res, exp_q.pop_front());
        check("wc_sw_ram0", ram[12'h700], 8'h11);
        check("wc_sw_ram1", ram[12'h701], 8'hEE);
        check("wc_sw_ram2", ram[12'h702], 8'hFF);
        check("wc_sw_ram3", ram[12'h703], 8'hC0);
        check("wc_sw_ram4", ram[12'h704], model[12'h704]);
        step();

        // ---------------- rdy low mid-load ----------------
        exp_q.push_back(32'hF2345678);
        bus.lsb_enable = 1'b1; bus.lsb_addr = 32'h100; bus.lsb_load = 1'b1; bus.lsb_op = 5'b00010;
        step();
        check("rdy_addr0", bus.mem_a, 32'h100);
        step();
        check("rdy_addr1", bus.mem_a, 32'h101);
        bus.rdy = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            check("rdy_hold_addr", bus.mem_a, 32'h101);
            check("rdy_hold_state", dbg_state, 1);
        end
        bus.rdy = 1'b1;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 10) begin
            step();
            edges++;
            if (bus.lsb_mem_valid) got = 1'b1;
        end
        bus.lsb_enable = 1'b0;
        check("rdy_resume_edges", edges, 3);
        check("rdy_res", bus.lsb_mem_res, exp_q.pop_front());
        step();

        // ---------------- asynchronous reset mid-store ----------------
        bus.lsb_enable = 1'b1; bus.lsb_addr = 32'h300; bus.lsb_data = 32'h44332211;
        bus.lsb_load = 1'b0; bus.lsb_op = 5'b00010;
        step();
        step();
        check("arst_pre_wr", bus.mem_wr, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_wr", bus.mem_wr, 0);
        check("arst_mem_a", bus.mem_a, 0);
        check("arst_dout", bus.mem_dout, 0);
        check("arst_lsb_res", bus.lsb_mem_res, 0);
        check("arst_if_res", bus.if_mem_res, 0);
        check("arst_lsb_valid", bus.lsb_mem_valid, 0);
        check("arst_state", dbg_state, 0);
        bus.lsb_enable = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        lsb_req(32'h100, 32'd0, 1'b1, 5'b00010, 32'hF2345678);
        check("arst_after_edges", edges, 5);

        check("sb_lsb_empty", exp_q.size(), 0);
        check("sb_if_empty", if_exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
